// File: rtl/apb4_mem_slave.sv
// APB4 completer backed by a word-organised memory with byte strobes,
// a fixed number of PREADY wait states, and PSLVERR on bad addresses.
module apb4_mem_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFS   = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    pready_q, pready_n;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_n;
    logic                    pslverr_q, pslverr_n;
    logic                    wr_q, wr_n;
    logic                    err_q, err_n;
    logic [IDX_W-1:0]        idx_q, idx_n;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
    logic [STRB_W-1:0]       strb_q, strb_n;
    logic                    commit;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // Address decode of the live bus, used only at the setup edge
    logic [ADDR_WIDTH-1:0]   addr_word;
    logic [IDX_W-1:0]        addr_idx;
    logic                    addr_err;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;

    assign addr_word = PADDR >> OFFS;
    assign addr_idx  = addr_word[IDX_W-1:0];
    assign addr_err  = (addr_word >= ADDR_WIDTH'(MEM_DEPTH)) ||
                       ((PADDR & ADDR_WIDTH'(STRB_W - 1)) != '0);

    // Zero-wait responses read at the setup edge, otherwise from the latched index
    assign rd_idx  = (state == IDLE) ? addr_idx : idx_q;
    assign rd_word = mem[rd_idx];

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pready_n  = pready_q;
        prdata_n  = prdata_q;
        pslverr_n = pslverr_q;
        wr_n      = wr_q;
        err_n     = err_q;
        idx_n     = idx_q;
        wdata_n   = wdata_q;
        strb_n    = strb_q;
        commit    = 1'b0;

        unique case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    wr_n    = PWRITE;
                    err_n   = addr_err;
                    idx_n   = addr_idx;
                    wdata_n = PWDATA;
                    strb_n  = PSTRB;
                    cnt_n   = CNT_W'(WAIT_STATES);
                    state_n = ACCESS;
                    if (WAIT_STATES == 0) begin
                        pready_n  = 1'b1;
                        prdata_n  = (PWRITE || addr_err) ? '0 : rd_word;
                        pslverr_n = addr_err;
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    // Requester abandoned the transfer: drop it without committing
                    state_n   = IDLE;
                    cnt_n     = '0;
                    pready_n  = 1'b0;
                    prdata_n  = '0;
                    pslverr_n = 1'b0;
                end else if (pready_q && PENABLE) begin
                    commit    = wr_q && !err_q;
                    state_n   = IDLE;
                    pready_n  = 1'b0;
                    prdata_n  = '0;
                    pslverr_n = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        pready_n  = 1'b1;
                        prdata_n  = (wr_q || err_q) ? '0 : rd_word;
                        pslverr_n = err_q;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered outputs and latched setup values
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt       <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
        end else begin
            cnt       <= cnt_n;
            pready_q  <= pready_n;
            prdata_q  <= prdata_n;
            pslverr_q <= pslverr_n;
            wr_q      <= wr_n;
            err_q     <= err_n;
            idx_q     <= idx_n;
            wdata_q   <= wdata_n;
            strb_q    <= strb_n;
        end
    end

    // Storage: cleared on reset, byte-lane writes at the completion edge
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (strb_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Scoreboard bench for apb4_mem_slave: one instance with two wait states,
// one zero-wait instance; a negedge monitor checks every completion.
module tb_apb4_mem_slave;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = DW / 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          preset  [2];
    logic          psel    [2];
    logic          penable [2];
    logic          pwrite  [2];
    logic [AW-1:0] paddr   [2];
    logic [DW-1:0] pwdata  [2];
    logic [SW-1:0] pstrb   [2];
    logic          pready  [2];
    logic [DW-1:0] prdata  [2];
    logic          pslverr [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    apb4_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(64), .WAIT_STATES(2)) dut_ws2 (
        .PCLK(clk), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb4_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(64), .WAIT_STATES(0)) dut_ws0 (
        .PCLK(clk), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pops the scoreboard on each completing cycle; outside one, outputs must be quiet
    task automatic monitor(input int d);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (psel[d] && penable[d] && pready[d]) begin
            if (d == 0 && q0.size() > 0) begin
                e = q0.pop_front();
                have = 1'b1;
            end else if (d == 1 && q1.size() > 0) begin
                e = q1.pop_front();
                have = 1'b1;
            end
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp dut%0d: PREADY high, no transfer expected", d);
            end else begin
                check({e.name, "_rdata"}, 64'(prdata[d]), 64'(e.rdata));
                check({e.name, "_slverr"}, 64'(pslverr[d]), 64'(e.err));
            end
        end else if (pready[d] === 1'b0) begin
            check($sformatf("quiet_out_dut%0d", d), {31'd0, pslverr[d], prdata[d]}, 64'd0);
        end else if (pready[d] === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL stray_ready dut%0d: PREADY=1 outside an access phase", d);
        end
    endtask

    always @(negedge clk) monitor(0);
    always @(negedge clk) monitor(1);

    // Full transfer starting just after a rising edge; scrambles the bus during access
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] exp_rd, input bit exp_err,
                        input string name, input bit b2b);
        exp_t e;
        int   acc;
        bit   ok;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.name  = name;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        pstrb[d]   = strb;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        paddr[d]   = addr ^ 32'h4;
        pwdata[d]  = ~data;
        pstrb[d]   = ~strb;
        acc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            acc++;
            @(negedge clk);
            if (pready[d] === 1'b1) ok = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: PREADY not seen after %0d access cycles, required %0d", name, acc, (d == 0) ? 3 : 1);
        end
        @(posedge clk); #1;
        check({name, "_len"}, 64'(1 + acc), 64'((d == 0) ? 4 : 2));
        penable[d] = 1'b0;
        if (!b2b) psel[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            preset[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        preset[0] = 1'b0;
        preset[1] = 1'b0;
        @(negedge clk);
        check("rst_pready", 64'(pready[0]), 64'd0);
        check("rst_prdata", 64'(prdata[0]), 64'd0);
        check("rst_pslverr", 64'(pslverr[0]), 64'd0);
        @(posedge clk); #1;

        // Two-wait-state instance
        xfer(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'h0,        1'b0, "rd_10_after_rst", 1'b0);
        xfer(0, 1'b1, 32'h08,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, "wr_08_full",      1'b0);
        xfer(0, 1'b0, 32'h08,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "rd_08_full",      1'b0);
        xfer(0, 1'b1, 32'h08,  32'h11223344, 4'h5, 32'h0,        1'b0, "wr_08_strb5",     1'b0);
        xfer(0, 1'b0, 32'h08,  32'h0,        4'h0, 32'hDE22BE44, 1'b0, "rd_08_merged",    1'b0);
        xfer(0, 1'b1, 32'h08,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, "wr_08_nostrb",    1'b0);
        xfer(0, 1'b1, 32'h100, 32'h55667788, 4'hF, 32'h0,        1'b1, "wr_100_oor",      1'b0);
        xfer(0, 1'b0, 32'h00,  32'h0,        4'h0, 32'h0,        1'b0, "rd_00_no_alias",  1'b0);
        xfer(0, 1'b0, 32'h08,  32'h0,        4'h0, 32'hDE22BE44, 1'b0, "rd_08_unchanged", 1'b0);
        xfer(0, 1'b0, 32'h0A,  32'h0,        4'h0, 32'h0,        1'b1, "rd_0a_misalign",  1'b0);
        xfer(0, 1'b1, 32'h0A,  32'h12345678, 4'hF, 32'h0,        1'b1, "wr_0a_misalign",  1'b0);
        xfer(0, 1'b0, 32'h08,  32'h0,        4'h0, 32'hDE22BE44, 1'b0, "rd_08_after_err", 1'b0);
        xfer(0, 1'b0, 32'hFC,  32'h0,        4'h0, 32'h0,        1'b0, "rd_fc_last",      1'b0);

        // Write abandoned by dropping PSEL in the second access cycle
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h0C; pwdata[0] = 32'h12345678; pstrb[0] = 4'hF;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        @(posedge clk); #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        check("abort_pready", 64'(pready[0]), 64'd0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h0C,  32'h0,        4'h0, 32'h0,        1'b0, "rd_0c_aborted",   1'b0);

        // Reset during the first wait cycle of a write
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 32'h04; pwdata[0] = 32'hCAFEF00D; pstrb[0] = 4'hF;
        @(posedge clk); #1;
        penable[0] = 1'b1;
        preset[0]  = 1'b1;
        @(posedge clk); #1;
        preset[0] = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        check("midrst_pready", 64'(pready[0]), 64'd0);
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h04,  32'h0,        4'h0, 32'h0,        1'b0, "rd_04_after_rst", 1'b0);

        // Zero-wait instance: stray PENABLE in IDLE must not start anything
        psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1;
        paddr[1] = 32'h00; pwdata[1] = 32'h77777777; pstrb[1] = 4'hF;
        @(negedge clk);
        check("stray_en_1", 64'(pready[1]), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("stray_en_2", 64'(pready[1]), 64'd0);
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;

        xfer(1, 1'b1, 32'h00,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0, "ws0_wr_00",       1'b1);
        xfer(1, 1'b0, 32'h00,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, "ws0_rd_00",       1'b1);
        xfer(1, 1'b1, 32'h3C,  32'h0BADF00D, 4'hC, 32'h0,        1'b0, "ws0_wr_3c_hi",    1'b1);
        xfer(1, 1'b0, 32'h3C,  32'h0,        4'h0, 32'h0BAD0000, 1'b0, "ws0_rd_3c",       1'b1);
        xfer(1, 1'b0, 32'h104, 32'h0,        4'h0, 32'h0,        1'b1, "ws0_rd_104_oor",  1'b0);

        repeat (3) @(posedge clk);
        check("sb_drain", 64'(q0.size() + q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb4_mem_slave.md
# apb4_mem_slave

APB4 completer with word-organised memory that sits directly downstream of the APB4 requester and answers its PSEL/PENABLE transfers. Supports byte-strobed writes, a parameterised number of wait states on PREADY, and PSLVERR for out-of-range or misaligned addresses. It is the memory model the requester drives in block-level and system simulation.

## Interface
- DATA_WIDTH, 32, PWDATA/PRDATA width (multiple of 8)
- ADDR_WIDTH, 32, PADDR width (byte address)
- MEM_DEPTH, 64, number of DATA_WIDTH words
- WAIT_STATES, 1, PREADY-low cycles inserted in every access phase (0 = zero-wait)
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- PSEL  in  1  completer select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte strobes (ignored on reads)
- PREADY  out  1  transfer completes on edge where PSEL&PENABLE&PREADY
- PRDATA  out  DATA_WIDTH  read data, valid only with PREADY on reads
- PSLVERR  out  1  error response, valid only with PREADY

## Operation
- Word index = PADDR >> log2(DATA_WIDTH/8). Error if index >= MEM_DEPTH or low address bits (byte offset) nonzero.
- FSM states: IDLE, ACCESS.
- IDLE: on edge with PSEL=1, PENABLE=0 (setup): latch PWRITE, index, error flag, PWDATA, PSTRB; load wait counter with WAIT_STATES; go ACCESS. If WAIT_STATES=0, assert PREADY at this same edge.
- ACCESS, counter > 0: decrement; when it reaches 0 (edge), assert PREADY and load response.
- Response loaded at the edge raising PREADY: read OK -> PRDATA = mem[index], PSLVERR=0; read error -> PRDATA=0, PSLVERR=1; write OK -> PRDATA=0, PSLVERR=0; write error -> PRDATA=0, PSLVERR=1.
- Completion edge (PSEL&PENABLE&PREADY): write OK commits byte lane i of latched data iff PSTRB[i]; PSTRB=0 -> no change, OKAY response. Error writes never modify memory. Clear PREADY, PRDATA, PSLVERR; go IDLE.
- Latched setup values are used for the whole transfer; changes on PADDR/PWDATA/PSTRB during ACCESS are ignored.
- PSEL dropped in ACCESS before completion (protocol violation): abort, no write, clear outputs, go IDLE.
- PENABLE=1 seen in IDLE without a preceding setup: ignored, no response.

## Timing
- Reset (PRESET=1 at edge, any state): FSM -> IDLE, PREADY=0, PRDATA=0, PSLVERR=0, counter=0, all memory words=0. Reset mid-transfer drops it; pending write not committed.
- All outputs registered; PREADY/PRDATA/PSLVERR are 0 in every cycle except the completing access cycle.
- Transfer length = 2 + WAIT_STATES cycles (setup + access incl. waits). WAIT_STATES=0 -> PREADY high in first access cycle.
- Back-to-back: requester's next setup cycle immediately follows completion; FSM is in IDLE for it, no extra bubble.
- Read-after-write to same address in consecutive transfers returns new data (write committed at completion edge before next setup edge).

## Test plan
- Reset: hold PRESET=1 two cycles, release -> PREADY=0, PRDATA=0, PSLVERR=0; read 0x10 returns 0x00000000, PSLVERR=0.
- WAIT_STATES=2: write 0xDEADBEEF to 0x08, PSTRB=4'hF -> PREADY low for 2 access cycles, high on 3rd; subsequent read of 0x08 returns 0xDEADBEEF with same wait pattern.
- Partial strobe: with 0x08=0xDEADBEEF, write 0x11223344, PSTRB=4'b0101 -> read 0x08 returns 0xDE22BE44.
- Errors (MEM_DEPTH=64): write 0x100 -> PSLVERR=1 with PREADY, no memory change; read 0x0A (misaligned) -> PSLVERR=1, PRDATA=0; read 0xFC -> PSLVERR=0.
- Reset mid-op: write 0xCAFEF00D to 0x04, assert PRESET in first wait cycle -> next cycle PREADY=0, FSM IDLE; read 0x04 returns 0.
- WAIT_STATES=0 back-to-back: write 0xA5A5A5A5 to 0x00, then immediately read 0x00 -> each transfer exactly 2 cycles, read returns 0xA5A5A5A5, PSLVERR=0.
